// File: rtl/instr_cycle_sequencer.sv
// ============================================================================
// Module      : instr_cycle_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with a
//               memory-handshake stall watchdog. Optional single-step HOLD
//               state is enabled by defining INSTR_SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_cycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        dec_gp_we,
    input  logic        im_ready,
    input  logic        dm_ready,
`ifdef INSTR_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        im_req,
    output logic        ir_we,
    output logic        dm_req,
    output logic        dm_we,
    output logic        gp_we,
    output logic        pc_we,
    output logic        fault,
    output logic [2:0]  state_o,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HOLD   = 3'd5,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0]       c_op_load  = 6'b100011;
    localparam logic [5:0]       c_op_store = 6'b101011;
    localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    // Single-step builds park in HOLD wherever the sequencer would return to FETCH.
`ifdef INSTR_SINGLE_STEP_EN
    localparam state_t c_fetch_entry = ST_HOLD;
`else
    localparam state_t c_fetch_entry = ST_FETCH;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [31:0]        r_retired;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_limit;
    logic               w_count_en;
    logic               w_im_req;
    logic               w_ir_we;
    logic               w_dm_req;
    logic               w_dm_we;
    logic               w_gp_we;
    logic               w_pc_we;
    logic               w_fault;

    assign w_is_load  = (opcode == c_op_load);
    assign w_is_store = (opcode == c_op_store);
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);
    // The limit is judged on the count this cycle would produce, so the
    // Nth consecutive not-ready cycle is the one that traps.
    assign w_limit    = (TIMEOUT_CYCLES != 0) && (w_cnt_inc >= c_timeout);

    always_comb begin
        w_state_next = r_state;
        w_count_en   = 1'b0;
        w_im_req     = 1'b0;
        w_ir_we      = 1'b0;
        w_dm_req     = 1'b0;
        w_dm_we      = 1'b0;
        w_gp_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_im_req = 1'b1;
                if (im_ready) begin
                    w_ir_we      = 1'b1;
                    w_state_next = ST_DECODE;
                end else begin
                    w_count_en = 1'b1;
                    if (w_limit) w_state_next = ST_FAULT;
                end
            end
            ST_DECODE: w_state_next = ST_EXEC;
            ST_EXEC: begin
                if (w_is_load || w_is_store) begin
                    w_state_next = ST_MEM;
                end else if (dec_gp_we) begin
                    w_state_next = ST_WB;
                end else begin
                    w_pc_we      = 1'b1;
                    w_state_next = c_fetch_entry;
                end
            end
            ST_MEM: begin
                w_dm_req = 1'b1;
                w_dm_we  = w_is_store;
                if (dm_ready) begin
                    if (w_is_store) begin
                        w_pc_we      = 1'b1;
                        w_state_next = c_fetch_entry;
                    end else begin
                        w_state_next = ST_WB;
                    end
                end else begin
                    w_count_en = 1'b1;
                    if (w_limit) w_state_next = ST_FAULT;
                end
            end
            ST_WB: begin
                w_gp_we      = 1'b1;
                w_pc_we      = 1'b1;
                w_state_next = c_fetch_entry;
            end
`ifdef INSTR_SINGLE_STEP_EN
            ST_HOLD: begin
                if (step) w_state_next = ST_FETCH;
            end
`endif
            ST_FAULT: w_fault = 1'b1;
            default:  w_state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end else if (w_count_en) begin
            w_cnt_next = w_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_fetch_entry;
            r_cnt     <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_pc_we) r_retired <= r_retired + 32'd1;
        end
    end

    // Reset masks every output so a mid-access reset can never commit.
    assign im_req  = ~reset & w_im_req;
    assign ir_we   = ~reset & w_ir_we;
    assign dm_req  = ~reset & w_dm_req;
    assign dm_we   = ~reset & w_dm_we;
    assign gp_we   = ~reset & w_gp_we;
    assign pc_we   = ~reset & w_pc_we;
    assign fault   = ~reset & w_fault;
    assign state_o = reset ? 3'd0 : r_state;
    assign retired = reset ? 32'd0 : r_retired;

endmodule

`default_nettype wire

// File: tb/tb_instr_cycle_sequencer.sv
// ============================================================================
// Module      : tb_instr_cycle_sequencer
// Description : Self-checking bench; per-instruction cycle traces are expanded
//               into an expected-output queue and compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_cycle_sequencer;

    localparam int          c_tmo    = 4;
    localparam logic [31:0] c_i_add  = 32'h0085_2020;
    localparam logic [31:0] c_i_lw   = 32'h8C85_0004;
    localparam logic [31:0] c_i_sw   = 32'hAC85_0004;
    localparam logic [31:0] c_i_beq  = 32'h1081_0004;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic [5:0]  opcode    = 6'd0;
    logic        dec_gp_we = 1'b0;
    logic        im_ready  = 1'b0;
    logic        dm_ready  = 1'b0;
    logic        im_req, ir_we, dm_req, dm_we, gp_we, pc_we, fault;
    logic [2:0]  state_o;
    logic [31:0] retired;

    instr_cycle_sequencer #(
        .TIMEOUT_CYCLES (c_tmo),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .dec_gp_we (dec_gp_we),
        .im_ready  (im_ready),
        .dm_ready  (dm_ready),
`ifdef INSTR_SINGLE_STEP_EN
        .step      (1'b1),
`endif
        .im_req    (im_req),
        .ir_we     (ir_we),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .gp_we     (gp_we),
        .pc_we     (pc_we),
        .fault     (fault),
        .state_o   (state_o),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        gw;
        logic        imr;
        logic        dmr;
        logic [2:0]  st;
        logic [5:0]  strb;    // {im_req, ir_we, dm_req, dm_we, gp_we, pc_we}
        logic        flt;
        logic [31:0] ret;
        logic        pin_en;
        logic [2:0]  pin_st;
        logic [31:0] pin_ret;
    } vec_t;

    vec_t        vq[$];
    vec_t        ce;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur      = 0;
    bit          active   = 1'b0;
    logic [31:0] m_ret    = 32'd0;
    bit          p_pend   = 1'b0;
    logic [2:0]  p_st     = 3'd0;
    logic [31:0] p_ret    = 32'd0;

    function automatic logic [5:0] rop();
        return 6'($urandom());
    endfunction

    function automatic logic rb();
        return 1'($urandom());
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic gw,
                       input logic imr, input logic dmr, input logic [2:0] st,
                       input logic [5:0] strb, input logic flt);
        vec_t e;
        e.rst = rst; e.op = op; e.gw = gw; e.imr = imr; e.dmr = dmr;
        e.st = st; e.strb = strb; e.flt = flt;
        e.ret     = rst ? 32'd0 : m_ret;
        e.pin_en  = p_pend;
        e.pin_st  = p_st;
        e.pin_ret = p_ret;
        p_pend    = 1'b0;
        vq.push_back(e);
        if (rst) m_ret = 32'd0;
        else if (strb[0]) m_ret = m_ret + 32'd1;
    endtask

    // Literal expectations written by hand, attached to the next or last cycle.
    task automatic pin_next(input logic [2:0] st, input logic [31:0] ret);
        p_pend = 1'b1; p_st = st; p_ret = ret;
    endtask

    task automatic pin_last(input logic [2:0] st, input logic [31:0] ret);
        vec_t e;
        e = vq[vq.size()-1];
        e.pin_en = 1'b1; e.pin_st = st; e.pin_ret = ret;
        vq[vq.size()-1] = e;
    endtask

    task automatic gen_reset(input int n);
        repeat (n) add(1'b1, rop(), rb(), rb(), rb(), 3'd0, 6'b000000, 1'b0);
    endtask

    task automatic gen_stall_fetch(input int n);
        repeat (n) add(1'b0, rop(), rb(), 1'b0, rb(), 3'd0, 6'b100000, 1'b0);
    endtask

    task automatic gen_fetch(input int d);
        gen_stall_fetch(d);
        add(1'b0, rop(), rb(), 1'b1, rb(), 3'd0, 6'b110000, 1'b0);
    endtask

    task automatic gen_fault(input int n);
        repeat (n) add(1'b0, rop(), rb(), 1'b1, 1'b1, 3'd7, 6'b000000, 1'b1);
    endtask

    task automatic gen_pre(input logic [31:0] word, input logic gw);
        logic [5:0] op;
        logic       mem;
        op  = word[31:26];
        mem = (op == 6'b100011) || (op == 6'b101011);
        add(1'b0, rop(), rb(), rb(), rb(), 3'd1, 6'b000000, 1'b0);
        if (mem || gw) add(1'b0, op, gw, rb(), rb(), 3'd2, 6'b000000, 1'b0);
        else           add(1'b0, op, gw, rb(), rb(), 3'd2, 6'b000001, 1'b0);
    endtask

    task automatic gen_mem_stall(input logic [31:0] word, input logic gw, input int n);
        logic [5:0] op;
        logic       s;
        op = word[31:26];
        s  = (op == 6'b101011);
        repeat (n) add(1'b0, op, gw, rb(), 1'b0, 3'd3, {2'b00, 1'b1, s, 2'b00}, 1'b0);
    endtask

    task automatic gen_instr(input logic [31:0] word, input logic gw, input int fd, input int md);
        logic [5:0] op;
        logic       ld, s;
        op = word[31:26];
        ld = (op == 6'b100011);
        s  = (op == 6'b101011);
        gen_fetch(fd);
        gen_pre(word, gw);
        if (ld || s) begin
            gen_mem_stall(word, gw, md);
            add(1'b0, op, gw, rb(), 1'b1, 3'd3, {2'b00, 1'b1, s, 1'b0, s}, 1'b0);
        end
        if (ld || (!s && gw)) add(1'b0, rop(), rb(), rb(), rb(), 3'd4, 6'b000011, 1'b0);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0h, expected %0h", cur, nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            ce = vq[cur];
            check("state_o", 32'(state_o), 32'(ce.st));
            check("im_req",  32'(im_req),  32'(ce.strb[5]));
            check("ir_we",   32'(ir_we),   32'(ce.strb[4]));
            check("dm_req",  32'(dm_req),  32'(ce.strb[3]));
            check("dm_we",   32'(dm_we),   32'(ce.strb[2]));
            check("gp_we",   32'(gp_we),   32'(ce.strb[1]));
            check("pc_we",   32'(pc_we),   32'(ce.strb[0]));
            check("fault",   32'(fault),   32'(ce.flt));
            check("retired", retired,      ce.ret);
            if (ce.pin_en) begin
                check("pin_state",   32'(state_o), 32'(ce.pin_st));
                check("pin_retired", retired,      ce.pin_ret);
            end
        end
    end

    initial begin
        gen_reset(2);
        // ADD: FETCH, DECODE, EXEC, WB
        gen_instr(c_i_add, 1'b1, 0, 0);   pin_last(3'd4, 32'd0);
        pin_next(3'd0, 32'd1);
        // LW with dm_ready two cycles after MEM entry
        gen_instr(c_i_lw, 1'b1, 0, 2);    pin_last(3'd4, 32'd1);
        pin_next(3'd0, 32'd2);
        // SW with immediate dm_ready
        gen_instr(c_i_sw, 1'b0, 0, 0);    pin_last(3'd3, 32'd2);
        pin_next(3'd0, 32'd3);
        // three back-to-back BEQs
        repeat (3) gen_instr(c_i_beq, 1'b0, 0, 0);
        pin_last(3'd2, 32'd5);
        pin_next(3'd0, 32'd6);
        // stalls just under the limit in both FETCH and MEM
        gen_instr(c_i_lw, 1'b1, c_tmo-1, c_tmo-1);
        pin_last(3'd4, 32'd6);
        // FETCH watchdog trap, sticky with im_ready high
        gen_stall_fetch(c_tmo);
        pin_next(3'd7, 32'd7);
        gen_fault(3);
        gen_reset(1);
        pin_next(3'd0, 32'd0);
        // ready on the limit cycle wins over the trap
        gen_fetch(c_tmo-1);
        pin_next(3'd1, 32'd0);
        gen_pre(c_i_beq, 1'b0);
        // MEM watchdog trap
        gen_fetch(0);
        gen_pre(c_i_lw, 1'b1);
        gen_mem_stall(c_i_lw, 1'b1, c_tmo);
        pin_next(3'd7, 32'd1);
        gen_fault(2);
        gen_reset(1);
        // reset while a load waits in MEM
        pin_next(3'd0, 32'd0);
        gen_fetch(0);
        gen_pre(c_i_lw, 1'b1);
        gen_mem_stall(c_i_lw, 1'b1, 1);
        add(1'b1, 6'b100011, 1'b1, 1'b1, 1'b1, 3'd0, 6'b000000, 1'b0);
        pin_last(3'd0, 32'd0);
        pin_next(3'd0, 32'd0);
        gen_instr(c_i_add, 1'b1, 0, 0);   pin_last(3'd4, 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            reset     = vq[i].rst;
            opcode    = vq[i].op;
            dec_gp_we = vq[i].gw;
            im_ready  = vq[i].imr;
            dm_ready  = vq[i].dmr;
            cur       = i;
            active    = 1'b1;
        end
        @(negedge clk);
        #1;
        active = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
